// File: rtl/mdu_sched_pkg.sv
// rtl/mdu_sched_pkg.sv - MDU op codes, default latencies and FSM state encodings.
// MADD/MADDU are accepted as multiply-class ops only when MDU_MADD_EN is defined.
package mdu_sched_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t OP_NONE  = 4'd0;
    localparam mdu_op_t OP_MULT  = 4'd1;
    localparam mdu_op_t OP_MULTU = 4'd2;
    localparam mdu_op_t OP_DIV   = 4'd3;
    localparam mdu_op_t OP_DIVU  = 4'd4;
    localparam mdu_op_t OP_MTHI  = 4'd5;
    localparam mdu_op_t OP_MTLO  = 4'd6;
    localparam mdu_op_t OP_MADD  = 4'd7;
    localparam mdu_op_t OP_MADDU = 4'd8;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_md_op(input mdu_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md_op = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  is_md_op = 1'b1;
`endif
            default:                            is_md_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath producing the next HI/LO.
// MADD/MADDU accumulate onto hi/lo only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        neg_q;
    logic        neg_r;

    // Signed divide runs on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        prod_u   = {32'd0, src_a} * {32'd0, src_b};
        prod_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        div_zero = (src_b == 32'd0);
        neg_q    = (op == OP_DIV) && (src_a[31] ^ src_b[31]);
        neg_r    = (op == OP_DIV) && src_a[31];
        mag_a    = ((op == OP_DIV) && src_a[31]) ? -src_a : src_a;
        mag_b    = ((op == OP_DIV) && src_b[31]) ? -src_b : src_b;
        divisor  = div_zero ? 32'd1 : mag_b;
        q_u      = mag_a / divisor;
        r_u      = mag_a % divisor;
        res_hi   = hi;
        res_lo   = lo;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                    res_lo = neg_q ? -q_u : q_u;
                    res_hi = neg_r ? -r_u : r_u;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
`endif
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - E-stage MDU sequencer: latency FSM, HI/LO ownership and stall request.
// MDU_MADD_EN adds MADD/MADDU as multiply-latency accumulate ops.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_mdu_use,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;
    logic        idle;

    mdu_arith u_arith (
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi       (hi_q),
        .lo       (lo_q),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign idle  = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_RUN);
    assign start = idle && op_valid && is_md_op(op);
    assign stall = start || (busy && d_mdu_use);
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Result is computed at accept and parked; HI/LO only change when the counter expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (start) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = !(is_div_op(op) && div_zero);
            cnt_d     = is_div_op(op) ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
            state_d   = ST_RUN;
        end else if (idle && op_valid && (op == OP_MTHI)) begin
            hi_d = src_a;
        end else if (idle && op_valid && (op == OP_MTLO)) begin
            lo_d = src_a;
        end else if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = ST_IDLE;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - self-checking bench for mdu_sched against a 64-bit arithmetic model.
// Expectations for MADD/MADDU follow MDU_MADD_EN.
module tb_mdu_sched;
    import mdu_sched_pkg::*;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_mdu_use;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    mdu_sched #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .d_mdu_use (d_mdu_use),
        .start     (start),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    function automatic bit madd_en();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_md(input logic [3:0] o);
        return (o >= 4'd1 && o <= 4'd4) || (madd_en() && (o == 4'd7 || o == 4'd8));
    endfunction

    function automatic int lat(input logic [3:0] o);
        return (o == 4'd3 || o == 4'd4) ? DIVN : MULN;
    endfunction

    // Next {hi,lo} from plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] hl);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            4'd1: return 64'(sa * sb);
            4'd2: return 64'(ua * ub);
            4'd3: return (b == 32'd0) ? hl : {32'(sa % sb), 32'(sa / sb)};
            4'd4: return (b == 32'd0) ? hl : {32'(ua % ub), 32'(ua / ub)};
            4'd5: return {a, hl[31:0]};
            4'd6: return {hl[63:32], a};
            4'd7: return madd_en() ? hl + 64'(sa * sb) : hl;
            4'd8: return madd_en() ? hl + 64'(ua * ub) : hl;
            default: return hl;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit du,
                          input bit junk, output bit st_acc, output bit stall_acc, output int nbusy,
                          output int nstall, output bit stall_after, output bit bad_start);
        op_valid = 1'b1; op = o; src_a = a; src_b = b; d_mdu_use = du;
        #1;
        st_acc = start;
        stall_acc = stall;
        tick();
        if (junk) begin
            op_valid = 1'b1; op = 4'($urandom_range(1, 6)); src_a = $urandom; src_b = $urandom;
        end else begin
            op_valid = 1'b0; op = OP_NONE;
        end
        #1;
        nbusy = 0; nstall = 0; bad_start = 1'b0;
        for (int g = 0; g < 40 && busy === 1'b1; g++) begin
            nbusy++;
            if (stall === 1'b1) nstall++;
            if (start !== 1'b0) bad_start = 1'b1;
            tick();
            op_valid = 1'b0; op = OP_NONE;
            #1;
        end
        stall_after = stall;
    endtask

    task automatic single(input logic [3:0] o, input logic [31:0] a);
        op_valid = 1'b1; op = o; src_a = a; src_b = 32'd0;
        tick();
        op_valid = 1'b0; op = OP_NONE;
        #1;
        {exp_hi, exp_lo} = model(o, a, 32'd0, {exp_hi, exp_lo});
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op = OP_NONE; src_a = '0; src_b = '0; d_mdu_use = 1'b0;
        tick(); tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        tick();
    endtask

    task automatic test_mult();
        bit sa, sc, sf, bs; int nb, ns;
        run_md(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, sa, sc, nb, ns, sf, bs);
        checks++; if (sa !== 1'b1) begin errors++; $display("FAIL mult_start: got %b expected 1", sa); end
        checks++; if (nb != MULN) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected %0d", nb, MULN); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFF1;
    endtask

    task automatic test_div();
        bit sa, sc, sf, bs; int nb, ns;
        run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, sa, sc, nb, ns, sf, bs);
        checks++; if (nb != DIVN) begin errors++; $display("FAIL div_busy_cycles: got %0d expected %0d", nb, DIVN); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
    endtask

    task automatic test_divu_stall();
        bit sa, sc, sf, bs; int nb, ns;
        run_md(OP_DIVU, 32'd7, 32'd2, 1'b1, 1'b0, sa, sc, nb, ns, sf, bs);
        checks++; if (sc !== 1'b1) begin errors++; $display("FAIL divu_stall_accept: got %b expected 1", sc); end
        checks++; if (ns != DIVN) begin errors++; $display("FAIL divu_stall_busy: got %0d expected %0d", ns, DIVN); end
        checks++; if (sf !== 1'b0) begin errors++; $display("FAIL divu_stall_after: got %b expected 0", sf); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 1", hi); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 3", lo); end
        exp_hi = 32'd1; exp_lo = 32'd3;
        d_mdu_use = 1'b0;
    endtask

    task automatic test_mthi_divzero();
        bit sa, sc, sf, bs; int nb, ns;
        op_valid = 1'b1; op = OP_MTHI; src_a = 32'h12345678;
        #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL mthi_start: got %b expected 0", start); end
        tick();
        op_valid = 1'b0; op = OP_NONE;
        #1;
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        exp_hi = 32'h12345678;
        run_md(OP_DIV, 32'd99, 32'd0, 1'b0, 1'b0, sa, sc, nb, ns, sf, bs);
        checks++; if (nb != DIVN) begin errors++; $display("FAIL div0_busy_cycles: got %0d expected %0d", nb, DIVN); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL div0_hi: got %h expected %h", hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL div0_lo: got %h expected %h", lo, exp_lo); end
    endtask

    task automatic test_overflow();
        bit sa, sc, sf, bs; int nb, ns;
        run_md(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, sa, sc, nb, ns, sf, bs);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ovf_hi: got %h expected 0", hi); end
        exp_hi = 32'd0; exp_lo = 32'h80000000;
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op = OP_MULTU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        tick();
        op_valid = 1'b0; op = OP_NONE;
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo: got %h expected 0", {hi, lo}); end
        repeat (12) tick();
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_no_late_write: got %h expected 0", {hi, lo}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_late: got %b expected 0", busy); end
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_madd();
        bit sa, sc, sf, bs; int nb, ns;
        logic [31:0] want_hi, want_lo;
        single(OP_MTHI, 32'd0);
        single(OP_MTLO, 32'hFFFFFFFF);
        want_hi = madd_en() ? 32'd1 : 32'd0;
        want_lo = madd_en() ? 32'd0 : 32'hFFFFFFFF;
        run_md(OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0, sa, sc, nb, ns, sf, bs);
        checks++; if (sa !== madd_en()) begin errors++; $display("FAIL maddu_start: got %b expected %b", sa, madd_en()); end
        checks++; if (nb != (madd_en() ? MULN : 0)) begin errors++; $display("FAIL maddu_busy_cycles: got %0d", nb); end
        checks++; if (hi !== want_hi) begin errors++; $display("FAIL maddu_hi: got %h expected %h", hi, want_hi); end
        checks++; if (lo !== want_lo) begin errors++; $display("FAIL maddu_lo: got %h expected %h", lo, want_lo); end
        exp_hi = want_hi; exp_lo = want_lo;
    endtask

    task automatic test_random();
        bit sa, sc, sf, bs, du, junk, v; int nb, ns;
        logic [3:0] o; logic [31:0] a, b; logic [63:0] r;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) a = 32'($signed(a) >>> 20);
            du = 1'($urandom_range(0, 1));
            if (is_md(o)) begin
                junk = 1'($urandom_range(0, 1));
                r = model(o, a, b, {exp_hi, exp_lo});
                run_md(o, a, b, du, junk, sa, sc, nb, ns, sf, bs);
                checks++; if (sa !== 1'b1) begin errors++; $display("FAIL rnd_start op=%0d: got %b expected 1", o, sa); end
                checks++; if (nb != lat(o)) begin errors++; $display("FAIL rnd_busy op=%0d: got %0d expected %0d", o, nb, lat(o)); end
                checks++; if (ns != (du ? lat(o) : 0)) begin errors++; $display("FAIL rnd_stall op=%0d: got %0d", o, ns); end
                checks++; if (bs !== 1'b0) begin errors++; $display("FAIL rnd_start_while_busy op=%0d: got %b expected 0", o, bs); end
                checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL rnd_hilo op=%0d a=%h b=%h: got %h expected %h", o, a, b, {hi, lo}, r); end
                {exp_hi, exp_lo} = r;
            end else begin
                v = 1'($urandom_range(0, 1));
                r = v ? model(o, a, b, {exp_hi, exp_lo}) : {exp_hi, exp_lo};
                op_valid = v; op = o; src_a = a; src_b = b; d_mdu_use = du;
                #1;
                checks++; if (start !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rnd_nomd_start op=%0d: got %b%b expected 00", o, start, stall); end
                tick();
                op_valid = 1'b0; op = OP_NONE;
                #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_nomd_busy op=%0d: got %b expected 0", o, busy); end
                checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL rnd_nomd_hilo op=%0d: got %h expected %h", o, {hi, lo}, r); end
                {exp_hi, exp_lo} = r;
            end
        end
        d_mdu_use = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divu_stall();
        test_mthi_divzero();
        test_overflow();
        test_reset_mid();
        test_madd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
